// File: rtl/alu_control_sequencer.sv
// Moore fetch / decode / register-register ALU execute sequencer driving the Datapath controls.
// Optional: define SEQ_FAST_DECODE_EN to drop the DEC cycle and decode IR while in T2.

module alu_control_sequencer #(
    parameter int OPW  = 5,
    parameter int SELW = 4,
    parameter int CNTW = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [31:0]     IR,
    input  logic            Stop,
    output logic            PC_Out,
    output logic            ZLO_Out,
    output logic            MDR_Out,
    output logic            MAR_In,
    output logic            PC_In,
    output logic            MDR_In,
    output logic            IR_In,
    output logic            Y_In,
    output logic            Z_In,
    output logic            IncPC,
    output logic            Read,
    output logic [SELW-1:0] CONTROL,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            R_In,
    output logic            R_Out,
    output logic            Run,
    output logic            Illegal,
    output logic [CNTW-1:0] Instr_Count
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_HALT
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic mdr_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic run;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_e          state_q, state_d;
    ctrl_t           ctrl_q;
    logic [SELW-1:0] control_q;
    logic [CNTW-1:0] cnt_q;
    logic [OPW-1:0]  opcode;
    logic            illegal_op;
    logic            unused_ir_fields;

    assign opcode = IR[31 -: OPW];
    // Register fields are decoded by the Datapath via Gra/Grb/Grc, not here.
    assign unused_ir_fields = ^IR[31-OPW:0];

    function automatic logic [SELW-1:0] alu_sel(input logic [OPW-1:0] op);
        logic [SELW-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD:  sel = SELW'(1);
            OP_SUB:  sel = SELW'(2);
            OP_AND:  sel = SELW'(3);
            OP_OR:   sel = SELW'(4);
            OP_SHR:  sel = SELW'(5);
            OP_SHL:  sel = SELW'(6);
            default: sel = '0;
        endcase
        return sel;
    endfunction

    function automatic state_e decode_next(input logic [OPW-1:0] op, input logic stop);
        state_e nxt;
        if (alu_sel(op) != '0)  nxt = S_T3;
        else if (op == OP_NOP)  nxt = stop ? S_HALT : S_T0;
        else if (op == OP_HALT) nxt = S_HALT;
        else                    nxt = S_T0;
        return nxt;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c     = '0;
        c.run = (s != S_RST) && (s != S_HALT);
        case (s)
            S_T0: begin c.pc_out  = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in   = 1'b1; end
            S_T1: begin c.zlo_out = 1'b1; c.pc_in  = 1'b1; c.read   = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in  = 1'b1; end
            S_T3: begin c.grb     = 1'b1; c.r_out  = 1'b1; c.y_in   = 1'b1; end
            S_T4: begin c.grc     = 1'b1; c.r_out  = 1'b1; c.z_in   = 1'b1; end
            S_T5: begin c.zlo_out = 1'b1; c.gra    = 1'b1; c.r_in   = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    assign illegal_op = (alu_sel(opcode) == '0) && (opcode != OP_NOP) && (opcode != OP_HALT);

    // NOTE: Reset is folded into state_d, so every register derived from it clears in the same edge.
    always_comb begin
        state_d = state_q;
        if (Reset) begin
            state_d = S_RST;
        end else begin
            case (state_q)
                S_RST:  state_d = S_T0;
                S_T0:   state_d = S_T1;
                S_T1:   state_d = S_T2;
`ifdef SEQ_FAST_DECODE_EN
                S_T2:   state_d = decode_next(opcode, Stop);
`else
                S_T2:   state_d = S_DEC;
`endif
                S_DEC:  state_d = decode_next(opcode, Stop);
                S_T3:   state_d = S_T4;
                S_T4:   state_d = S_T5;
                S_T5:   state_d = Stop ? S_HALT : S_T0;
                S_HALT: state_d = S_HALT;
                default: state_d = S_RST;
            endcase
        end
    end

    // NOTE: Outputs are registered from the next state, so they are glitch-free functions of state_q.
    always_ff @(posedge Clock) begin
        state_q   <= state_d;
        ctrl_q    <= decode_ctrl(state_d);
        control_q <= (state_d == S_T4) ? alu_sel(opcode) : '0;
        if (Reset) begin
            cnt_q <= '0;
        end else if (state_q == S_T5) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

`ifdef SEQ_FAST_DECODE_EN
    logic illegal_q;

    // IR is only guaranteed during T2 here, so the flag is captured and shown one cycle later.
    always_ff @(posedge Clock) begin
        if (Reset) illegal_q <= 1'b0;
        else       illegal_q <= (state_q == S_T2) && illegal_op;
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = (state_q == S_DEC) && illegal_op;
`endif

    assign PC_Out      = ctrl_q.pc_out;
    assign ZLO_Out     = ctrl_q.zlo_out;
    assign MDR_Out     = ctrl_q.mdr_out;
    assign MAR_In      = ctrl_q.mar_in;
    assign PC_In       = ctrl_q.pc_in;
    assign MDR_In      = ctrl_q.mdr_in;
    assign IR_In       = ctrl_q.ir_in;
    assign Y_In        = ctrl_q.y_in;
    assign Z_In        = ctrl_q.z_in;
    assign IncPC       = ctrl_q.inc_pc;
    assign Read        = ctrl_q.read;
    assign Gra         = ctrl_q.gra;
    assign Grb         = ctrl_q.grb;
    assign Grc         = ctrl_q.grc;
    assign R_In        = ctrl_q.r_in;
    assign R_Out       = ctrl_q.r_out;
    assign Run         = ctrl_q.run;
    assign CONTROL     = control_q;
    assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: per-cycle expected control words are queued with
// their stimulus, then each entry is driven, and the DUT outputs are compared on the falling edge.

module tb_alu_control_sequencer;

`ifdef SEQ_FAST_DECODE_EN
    localparam logic FAST = 1'b1;
`else
    localparam logic FAST = 1'b0;
`endif

    localparam logic [31:0] IR_ADD  = 32'h19A0_0000;
    localparam logic [31:0] IR_SUB  = 32'h2128_0000;
    localparam logic [31:0] IR_AND  = 32'h2890_8000;
    localparam logic [31:0] IR_OR   = 32'h3000_0000;
    localparam logic [31:0] IR_SHR  = 32'h3800_0000;
    localparam logic [31:0] IR_SHL  = 32'h4000_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;

    typedef enum {E_RST, E_T0, E_T1, E_T2, E_DEC, E_T3, E_T4, E_T5, E_HALT} st_e;

    typedef struct packed {
        logic pc_out, zlo_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
        logic inc_pc, read, gra, grb, grc, r_in, r_out, run, illegal;
        logic [3:0]  control;
        logic [15:0] count;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        stop;
        logic [31:0] ir;
        obs_t        exp;
    } item_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = '0;
    logic PC_Out, ZLO_Out, MDR_Out, MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, IncPC, Read;
    logic Gra, Grb, Grc, R_In, R_Out, Run, Illegal;
    logic [3:0]  CONTROL;
    logic [15:0] Instr_Count;

    item_t       sb[$];
    logic [31:0] cur_ir;
    logic        cur_stop;
    logic [15:0] cnt_model;
    int          errors = 0;
    int          checks = 0;

    alu_control_sequencer #(.OPW(5), .SELW(4), .CNTW(16)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
        .PC_Out(PC_Out), .ZLO_Out(ZLO_Out), .MDR_Out(MDR_Out),
        .MAR_In(MAR_In), .PC_In(PC_In), .MDR_In(MDR_In), .IR_In(IR_In),
        .Y_In(Y_In), .Z_In(Z_In), .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_In(R_In), .R_Out(R_Out),
        .Run(Run), .Illegal(Illegal), .Instr_Count(Instr_Count)
    );

    always #5 Clock = ~Clock;

    function automatic obs_t exp_obs(st_e s, logic [3:0] sel, logic ill, logic [15:0] cnt);
        obs_t o;
        o         = '0;
        o.count   = cnt;
        o.illegal = ill;
        o.run     = (s != E_RST) && (s != E_HALT);
        case (s)
            E_RST: o.count = '0;
            E_T0:  begin o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; end
            E_T1:  begin o.zlo_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1; end
            E_T2:  begin o.mdr_out = 1; o.ir_in = 1; end
            E_T3:  begin o.grb = 1; o.r_out = 1; o.y_in = 1; end
            E_T4:  begin o.grc = 1; o.r_out = 1; o.z_in = 1; o.control = sel; end
            E_T5:  begin o.zlo_out = 1; o.gra = 1; o.r_in = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{pc_out: PC_Out, zlo_out: ZLO_Out, mdr_out: MDR_Out, mar_in: MAR_In, pc_in: PC_In,
              mdr_in: MDR_In, ir_in: IR_In, y_in: Y_In, z_in: Z_In, inc_pc: IncPC, read: Read,
              gra: Gra, grb: Grb, grc: Grc, r_in: R_In, r_out: R_Out, run: Run, illegal: Illegal,
              control: CONTROL, count: Instr_Count};
        return o;
    endfunction

    // Queue the state expected after the next rising edge, with the inputs applied before it.
    task automatic push(input st_e s, input logic [3:0] sel = 4'd0, input logic ill = 1'b0);
        item_t it;
        if (s == E_RST) cnt_model = '0;
        it.rst  = (s == E_RST);
        it.stop = cur_stop;
        it.ir   = cur_ir;
        it.exp  = exp_obs(s, sel, ill, cnt_model);
        sb.push_back(it);
    endtask

    // The new IR appears while T2 runs, as the Datapath latch would make it visible.
    task automatic push_fetch(input logic [31:0] ir, input logic dec_ill, input logic prev_ill);
        push(E_T0, 4'd0, prev_ill);
        push(E_T1);
        cur_ir = ir;
        push(E_T2);
        if (!FAST) push(E_DEC, 4'd0, dec_ill);
    endtask

    task automatic push_alu(input logic [31:0] ir, input logic [3:0] sel, input logic prev_ill = 1'b0);
        push_fetch(ir, 1'b0, prev_ill);
        push(E_T3);
        push(E_T4, sel);
        push(E_T5);
        cnt_model = cnt_model + 16'd1;
    endtask

    task automatic test_reset();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        cur_ir   = IR_ADD;
        repeat (3) push(E_RST);
        push(E_T0);
        push(E_T1);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_add();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_alu(IR_ADD, 4'd1);
        push(E_T0);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL add cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_illegal();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_fetch(IR_ILL, 1'b1, 1'b0);
        push_alu(IR_ADD, 4'd1, FAST);
        push(E_T0);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL illegal cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_stop_halt();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_fetch(IR_SUB, 1'b0, 1'b0);
        push(E_T3);
        cur_stop = 1'b1;
        push(E_T4, 4'd2);
        push(E_T5);
        cnt_model = cnt_model + 16'd1;
        push(E_HALT);
        cur_stop = 1'b0;
        repeat (11) push(E_HALT);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL stop_halt cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_nop_halt();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_fetch(IR_NOP, 1'b0, 1'b0);
        push_alu(IR_ADD, 4'd1);
        push_fetch(IR_NOP, 1'b0, 1'b0);
        cur_stop = 1'b1;
        repeat (3) push(E_HALT);
        cur_stop = 1'b0;
        push(E_RST);
        push_fetch(IR_HALT, 1'b0, 1'b0);
        repeat (3) push(E_HALT);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL nop_halt cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_alu(IR_ADD, 4'd1);
        push_fetch(IR_AND, 1'b0, 1'b0);
        push(E_T3);
        push(E_T4, 4'd3);
        push(E_RST);
        push(E_T0);
        push(E_T1);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        obs_t  got;
        cur_stop = 1'b0;
        push(E_RST);
        push_alu(IR_ADD, 4'd1);
        push_alu(IR_ADD, 4'd1);
        push_alu(IR_OR,  4'd4);
        push_alu(IR_SHR, 4'd5);
        push_alu(IR_SHL, 4'd6);
        push(E_T0);
        for (int cyc = 0; sb.size() != 0; cyc++) begin
            it = sb.pop_front();
            Reset = it.rst; Stop = it.stop; IR = it.ir;
            @(negedge Clock);
            got = sample();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got=%h expected=%h", cyc, got, it.exp);
            end
        end
    endtask

    initial begin
        cnt_model = '0;
        cur_ir    = '0;
        cur_stop  = 1'b0;
        test_reset();
        test_add();
        test_illegal();
        test_stop_halt();
        test_nop_halt();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
